// File: rtl/charmap_pipe.sv
// Character-map overlay pipeline.
// Turns a raster position into one overlay pixel in three clock-enabled stages:
//   stage 0 forms the character RAM address,
//   stage 1 forms the font ROM address from the returned character code,
//   stage 2 selects the glyph bit and applies cell inversion and the blinking cursor.
// Provides a once-per-frame blink timer for the cursor.
module charmap_pipe #(
  parameter int COL_BITS     = 6,
  parameter int ROW_BITS     = 5,
  parameter int BLINK_FRAMES = 16,
  parameter int INVERSE_EN   = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         ce_pix,
  input  logic [9:0]                   hcnt,
  input  logic [9:0]                   vcnt,
  input  logic [ROW_BITS-1:0]          scroll_row,
  input  logic                         cursor_en,
  input  logic [COL_BITS-1:0]          cursor_x,
  input  logic [ROW_BITS-1:0]          cursor_y,
  input  logic [7:0]                   chmap_data_out,
  input  logic [7:0]                   chrom_data_out,
  output logic [ROW_BITS+COL_BITS-1:0] chram_addr,
  output logic [11:0]                  chrom_addr,
  output logic                         a,
  output logic                         a_valid
);

  // Active window size in pixels/lines (8 pixels per cell in each direction).
  localparam logic [10:0] H_LIMIT    = 11'(8 << COL_BITS);
  localparam logic [10:0] V_LIMIT    = 11'(8 << ROW_BITS);
  localparam logic [7:0]  BLINK_LAST = 8'(BLINK_FRAMES - 1);
  localparam logic        INV_ON     = 1'(INVERSE_EN != 0);

  // Glyph index into the font ROM.
  // When inversion is enabled, bit 7 of the code is an attribute rather than part of the glyph index.
  function automatic logic [7:0] rom_code(input logic [7:0] code);
    rom_code = INV_ON ? {1'b0, code[6:0]} : code;
  endfunction

  // Glyph rows are stored MSB-first: pixel 0 is the leftmost (bit 7).
  function automatic logic glyph_bit(input logic [7:0] glyph, input logic [2:0] px);
    glyph_bit = glyph[3'd7 - px];
  endfunction

  // Stage 0 signals (combinational from the raster position)
  logic [COL_BITS-1:0] col_p0;
  logic [ROW_BITS-1:0] srow_p0;
  logic [ROW_BITS-1:0] row_p0;
  logic                vld_p0;
  logic                cur_p0;

  // Stage 1 registers
  logic [2:0]          px_p1;
  logic [2:0]          line_p1;
  logic                vld_p1;
  logic                cur_p1;
  logic                inv_p1;

  // Stage 2 registers
  logic [2:0]          px_p2;
  logic                vld_p2;
  logic                cur_p2;
  logic                inv_p2;
  logic                pix_p2;

  // Frame detection and cursor blink state
  logic [9:0]          vcnt_prev;
  logic [7:0]          blink_cnt;
  logic                blink_phase;
  logic                frame_start;

  // ---- stage 0: cell address, window test and cursor match ----
  // Scrolled row wraps modulo the row count.
  // The cursor is matched against the unscrolled screen row.
  always_comb begin
    col_p0  = hcnt[COL_BITS+2:3];
    srow_p0 = vcnt[ROW_BITS+2:3];
    row_p0  = srow_p0 + scroll_row;
    vld_p0  = ({1'b0, hcnt} < H_LIMIT) && ({1'b0, vcnt} < V_LIMIT);
    cur_p0  = cursor_en && (srow_p0 == cursor_y) && (col_p0 == cursor_x);
  end

  assign chram_addr = {row_p0, col_p0};

  // ---- stage 1: pixel/line position travels alongside the RAM read ----
  always_ff @(posedge clk) begin
    if (ce_pix) begin
      px_p1   <= hcnt[2:0];
      line_p1 <= vcnt[2:0];
    end
  end

  // Stage 1 window and cursor flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1 <= 1'b0;
      cur_p1 <= 1'b0;
    end else if (ce_pix) begin
      vld_p1 <= vld_p0;
      cur_p1 <= cur_p0;
    end
  end

  // Font ROM address built from the character code now on the RAM output.
  always_comb begin
    chrom_addr = {1'b0, rom_code(chmap_data_out), line_p1};
    inv_p1     = INV_ON & chmap_data_out[7];
  end

  // ---- stage 2: pixel index travels alongside the ROM read ----
  always_ff @(posedge clk) begin
    if (ce_pix) begin
      px_p2 <= px_p1;
    end
  end

  // Stage 2 window, cursor and inverse flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p2 <= 1'b0;
      cur_p2 <= 1'b0;
      inv_p2 <= 1'b0;
    end else if (ce_pix) begin
      vld_p2 <= vld_p1;
      cur_p2 <= cur_p1;
      inv_p2 <= inv_p1;
    end
  end

  // Glyph bit with cell inversion and visible cursor combined by XOR.
  // When both apply they cancel.
  always_comb begin
    pix_p2 = glyph_bit(chrom_data_out, px_p2) ^ inv_p2 ^ (cur_p2 & blink_phase);
  end

  // ---- stage 3: registered overlay pixel, forced low outside the window ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a       <= 1'b0;
      a_valid <= 1'b0;
    end else if (ce_pix) begin
      a       <= pix_p2 & vld_p2;
      a_valid <= vld_p2;
    end
  end

  // A frame starts when the line counter returns to zero from any other value.
  assign frame_start = ce_pix && (vcnt == '0) && (vcnt_prev != '0);

  // Last line counter value seen on an enabled pixel
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vcnt_prev <= '0;
    end else if (ce_pix) begin
      vcnt_prev <= vcnt;
    end
  end

  // Blink timer: counts frame starts.
  // The phase toggles every BLINK_FRAMES frames.
  // It runs whether or not the cursor is enabled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (frame_start) begin
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_charmap_pipe.sv
// Bench for charmap_pipe: table vectors, directed multi-cycle sequences and a
// randomized run checked against an arithmetic reference model.
module tb_charmap_pipe;
  localparam int BF = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ce_pix = 1'b0;
  logic [9:0]  hcnt = '0;
  logic [9:0]  vcnt = '0;
  logic [4:0]  scroll_row = '0;
  logic        cursor_en = 1'b0;
  logic [5:0]  cursor_x = '0;
  logic [4:0]  cursor_y = '0;
  logic [7:0]  chmap_data_out;
  logic [7:0]  chrom_data_out;
  logic [10:0] chram_addr;
  logic [11:0] chrom_addr;
  logic        a;
  logic        a_valid;

  logic [7:0]  chram [0:2047];
  logic [7:0]  chrom [0:4095];

  typedef struct { int h; int v; int sc; bit cen; int cx; int cy; } pix_t;
  typedef struct { int h; int v; int sc; bit ea; bit ev; } pvec_t;
  typedef struct { int h; int v; int sc; int addr; } avec_t;

  int         n_vec = 0;
  int         n_err = 0;
  pix_t       pend[$];
  int         fs_cnt;
  int         prev_v;
  logic [1:0] exp_out;

  charmap_pipe #(.COL_BITS(6), .ROW_BITS(5), .BLINK_FRAMES(BF), .INVERSE_EN(1)) dut (
    .clk(clk), .reset(reset), .ce_pix(ce_pix), .hcnt(hcnt), .vcnt(vcnt),
    .scroll_row(scroll_row), .cursor_en(cursor_en), .cursor_x(cursor_x),
    .cursor_y(cursor_y), .chmap_data_out(chmap_data_out),
    .chrom_data_out(chrom_data_out), .chram_addr(chram_addr),
    .chrom_addr(chrom_addr), .a(a), .a_valid(a_valid)
  );

  always #5 clk = ~clk;

  // Synchronous character RAM and font ROM, one enabled clock of read latency.
  always @(posedge clk) begin
    if (ce_pix) begin
      chmap_data_out <= chram[chram_addr];
      chrom_data_out <= chrom[chrom_addr];
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference pixel: {a, a_valid} from the screen rules in plain arithmetic.
  function automatic logic [1:0] eval(pix_t p, bit phase);
    int col, srow, row, line, px, idx;
    logic [7:0] code, glyph;
    bit cur, bv;
    if (p.h >= 512 || p.v >= 256) return 2'b00;
    col   = p.h / 8;
    srow  = p.v / 8;
    row   = (srow + p.sc) % 32;
    line  = p.v % 8;
    px    = p.h % 8;
    code  = chram[row * 64 + col];
    idx   = int'(code & 8'h7F) * 8 + line;
    glyph = chrom[idx];
    bv    = glyph[7 - px];
    cur   = p.cen && (srow == p.cy) && (col == p.cx);
    return {bv ^ code[7] ^ (cur & phase), 1'b1};
  endfunction

  function automatic bit phase_now();
    return ((fs_cnt / BF) % 2) == 1;
  endfunction

  function automatic void model_reset();
    pix_t idle;
    idle = '{1023, 1023, 0, 1'b0, 0, 0};
    pend.delete();
    pend.push_back(idle);
    pend.push_back(idle);
    fs_cnt  = 0;
    prev_v  = 0;
    exp_out = 2'b00;
  endfunction

  task automatic check(string nm, logic [1:0] act, logic [1:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s @%0t: a,a_valid=%b required %b", nm, $time, act, req);
    end
  endtask

  task automatic check_addr(string nm, logic [10:0] act, logic [10:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s @%0t: chram_addr=%h required %h", nm, $time, act, req);
    end
  endtask

  task automatic check_bit(string nm, logic act, logic req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s @%0t: got %b required %b", nm, $time, act, req);
    end
  endtask

  // One clock: drive inputs, check the combinational address, advance the
  // model on enabled edges and compare the registered outputs.
  task automatic step(bit ce, int h, int v, int sc, bit cen, int cx, int cy);
    pix_t p;
    int   ea;
    ce_pix = ce; hcnt = 10'(h); vcnt = 10'(v); scroll_row = 5'(sc);
    cursor_en = cen; cursor_x = 6'(cx); cursor_y = 5'(cy);
    #1;
    ea = (((v / 8) % 32 + sc) % 32) * 64 + (h / 8) % 64;
    check_addr("chram_addr", chram_addr, 11'(ea));
    @(posedge clk);
    if (ce) begin
      p = '{h, v, sc, cen, cx, cy};
      pend.push_back(p);
      exp_out = eval(pend.pop_front(), phase_now());
      if (v == 0 && prev_v != 0) fs_cnt++;
      prev_v = v;
    end
    #1;
    check("model", {a, a_valid}, exp_out);
  endtask

  task automatic flush();
    step(1'b1, 600, 300, 0, 1'b0, 0, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    ce_pix = 1'b1;
    #1;
    check("reset out", {a, a_valid}, 2'b00);
    @(posedge clk);
    #1;
    check("reset out held", {a, a_valid}, 2'b00);
    check_bit("reset blink_phase", dut.blink_phase, 1'b0);
    reset = 1'b0;
    model_reset();
  endtask

  // Present one cursor-row pixel and check it three clocks later.
  task automatic probe(string nm, int h, int v, int cx, bit ea);
    step(1'b1, h, v, 0, 1'b1, cx, 0);
    flush();
    flush();
    check(nm, {a, a_valid}, {ea, 1'b1});
  endtask

  pvec_t ptab [18];
  avec_t atab [6];
  int    c36_h [8];
  int    c36_v [8];
  bit    c36_ce [8];
  bit    c36_ea [8];
  bit    c36_ev [8];

  initial begin
    ptab = '{
      '{0, 0, 0, 1'b1, 1'b1}, '{1, 0, 0, 1'b0, 1'b1}, '{2, 0, 0, 1'b0, 1'b1},
      '{3, 0, 0, 1'b0, 1'b1}, '{4, 0, 0, 1'b0, 1'b1}, '{5, 0, 0, 1'b0, 1'b1},
      '{6, 0, 0, 1'b0, 1'b1}, '{7, 0, 0, 1'b1, 1'b1},
      '{512, 0, 0, 1'b0, 1'b0}, '{7, 256, 0, 1'b0, 1'b0}, '{520, 0, 0, 1'b0, 1'b0},
      '{8, 0, 0, 1'b1, 1'b1}, '{13, 3, 0, 1'b1, 1'b1}, '{16, 0, 0, 1'b0, 1'b1},
      '{0, 0, 1, 1'b1, 1'b1}, '{1, 0, 1, 1'b0, 1'b1}, '{0, 8, 31, 1'b1, 1'b1},
      '{3, 0, 0, 1'b0, 1'b1}
    };
    atab = '{
      '{8, 0, 1, 'h041}, '{0, 8, 31, 'h000}, '{511, 255, 0, 'h7FF},
      '{100, 40, 3, 'h20C}, '{8, 248, 1, 'h001}, '{17, 16, 0, 'h082}
    };
    c36_h  = '{0, 5, 5, 1, 7, 5, 600, 600};
    c36_v  = '{0, 0, 0, 0, 0, 0, 300, 300};
    c36_ce = '{1, 0, 0, 1, 1, 0, 1, 1};
    c36_ea = '{0, 0, 0, 0, 1, 1, 0, 1};
    c36_ev = '{0, 0, 0, 0, 1, 1, 1, 1};

    for (int i = 0; i < 2048; i++) chram[i] = 8'($urandom);
    for (int i = 0; i < 4096; i++) chrom[i] = 8'($urandom);
    chram[0]  = 8'h41; chrom[8'h41 * 8 + 0] = 8'h81; chrom[8'h41 * 8 + 1] = 8'h00;
    chram[1]  = 8'h02; for (int i = 0; i < 8; i++) chrom[16 + i] = 8'hFF;
    chram[2]  = 8'h82;
    chram[3]  = 8'hC1;
    chram[64] = 8'h03; chrom[24] = 8'h80;

    model_reset();
    do_reset();

    // Reset-state output, then the pixel table with its 3-clock latency.
    for (int i = 0; i < 20; i++) begin
      if (i < 18) step(1'b1, ptab[i].h, ptab[i].v, ptab[i].sc, 1'b0, 0, 0);
      else flush();
      if (i >= 2) check("pixel table", {a, a_valid}, {ptab[i-2].ea, ptab[i-2].ev});
    end

    // Character RAM addressing including scroll wrap (no clock edge here).
    ce_pix = 1'b0;
    for (int i = 0; i < 6; i++) begin
      hcnt = 10'(atab[i].h); vcnt = 10'(atab[i].v); scroll_row = 5'(atab[i].sc);
      #1;
      check_addr("addr table", chram_addr, 11'(atab[i].addr));
    end

    // Clock-enable gating: outputs hold and latency counts enabled edges only.
    for (int i = 0; i < 8; i++) begin
      step(c36_ce[i], c36_h[i], c36_v[i], 0, 1'b0, 0, 0);
      check("ce hold", {a, a_valid}, {c36_ea[i], c36_ev[i]});
    end

    // Cursor blink with BLINK_FRAMES=2 and its interaction with inverse cells.
    do_reset();
    step(1'b1, 600, 0, 0, 1'b0, 0, 0);
    probe("blink frame0", 1, 1, 0, 1'b0);
    step(1'b1, 600, 0, 0, 1'b0, 0, 0);
    probe("blink frame1", 1, 1, 0, 1'b0);
    step(1'b1, 600, 0, 0, 1'b0, 0, 0);
    probe("blink frame2", 1, 1, 0, 1'b1);
    step(1'b1, 600, 0, 0, 1'b0, 0, 0);
    probe("blink frame3", 1, 1, 0, 1'b1);
    probe("inverse+cursor", 25, 1, 3, 1'b0);
    probe("inverse only", 25, 1, 0, 1'b1);
    step(1'b1, 600, 0, 0, 1'b0, 0, 0);
    probe("blink frame4", 1, 1, 0, 1'b0);

    // Asynchronous reset while a=1 and the cursor phase is on.
    step(1'b1, 600, 0, 0, 1'b0, 0, 0);
    flush();
    step(1'b1, 600, 0, 0, 1'b0, 0, 0);
    flush();
    step(1'b1, 0, 0, 0, 1'b0, 0, 0);
    flush();
    flush();
    check("pre-reset pixel", {a, a_valid}, 2'b11);
    check_bit("pre-reset blink_phase", dut.blink_phase, 1'b1);
    #1;
    reset = 1'b1;
    #1;
    check("async reset out", {a, a_valid}, 2'b00);
    check_bit("async reset blink_phase", dut.blink_phase, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    step(1'b1, 0, 0, 0, 1'b0, 0, 0);
    check("fill 1", {a, a_valid}, 2'b00);
    step(1'b1, 0, 0, 0, 1'b0, 0, 0);
    check("fill 2", {a, a_valid}, 2'b00);
    step(1'b1, 0, 0, 0, 1'b0, 0, 0);
    check("after fill", {a, a_valid}, 2'b11);

    // Randomized run against the reference model.
    for (int i = 0; i < 3000; i++) begin
      int h, v, sc, cx, cy;
      bit ce, cen;
      ce  = ($urandom % 4) != 0;
      h   = $urandom_range(0, 639);
      v   = (($urandom % 10) == 0) ? 0 : $urandom_range(0, 299);
      sc  = $urandom % 32;
      cen = $urandom % 2;
      cx  = ($urandom % 2) ? (h / 8) % 64 : $urandom % 64;
      cy  = ($urandom % 2) ? (v / 8) % 32 : $urandom % 32;
      step(ce, h, v, sc, cen, cx, cy);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
